// File: rtl/pdm_decoder_if.sv
// PDM decoder bus: two PDM bit streams in, two decoded PCM samples plus a sample strobe out.
interface pdm_decoder_if;
  logic        lft_PDM;
  logic        rght_PDM;
  logic [15:0] lft_inverse;
  logic [15:0] rght_inverse;
  logic        smp_vld;

  // Stimulus / PDM source side
  modport master (
    output lft_PDM, rght_PDM,
    input  lft_inverse, rght_inverse, smp_vld
  );

  // Decoder side
  modport slave (
    input  lft_PDM, rght_PDM,
    output lft_inverse, rght_inverse, smp_vld
  );
endinterface

// File: rtl/pdm_decoder.sv
// pdm_decoder: per-channel boxcar (moving-sum) PDM-to-PCM recovery with decimated,
// saturated 16-bit signed outputs.
// Optional feature macro: PDM_DEC_IIR_EN adds a first-order IIR post-filter per channel.
module pdm_decoder #(
  parameter int unsigned WIN_LOG2  = 8,
  parameter int unsigned DEC_LOG2  = 0,
  parameter int unsigned IIR_SHIFT = 4
) (
  input  logic          clk,
  input  logic          RST_n,
  pdm_decoder_if.slave  bus
);

  localparam int unsigned WIN   = 1 << WIN_LOG2;
  localparam int unsigned SUM_W = WIN_LOG2 + 1;
  localparam int unsigned SHIFT = 16 - WIN_LOG2;

  // History resets to an alternating window (oldest bit 0), so the running sum starts at mid-scale.
  localparam logic [WIN-1:0]   HIST_RST = {(WIN/2){2'b01}};
  localparam logic [SUM_W-1:0] SUM_RST  = SUM_W'(WIN/2);

  // Reject illegal parameter combinations at elaboration
  if (WIN_LOG2 < 4 || WIN_LOG2 > 16 || DEC_LOG2 > 8 || IIR_SHIFT < 1 || IIR_SHIFT > 8) begin : g_bad_param
    $error("pdm_decoder: parameter out of legal range");
  end

  // Clamp an 18-bit signed value into 16-bit two's complement
  function automatic logic [15:0] sat16(input logic signed [17:0] v);
    if (v > 18'sd32767)
      return 16'h7FFF;
    else if (v < -18'sd32768)
      return 16'h8000;
    else
      return v[15:0];
  endfunction

  logic wrap_c;
  logic vld_q;

  if (DEC_LOG2 == 0) begin : g_nodec
    assign wrap_c = 1'b1;
  end else begin : g_dec
    logic [DEC_LOG2-1:0] cnt;

    // Free-running decimation counter; wrap marks an output-update edge
    always_ff @(posedge clk or negedge RST_n) begin
      if (!RST_n)
        cnt <= '0;
      else
        cnt <= cnt + DEC_LOG2'(1);
    end

    assign wrap_c = (cnt == {DEC_LOG2{1'b1}});
  end

  // Sample strobe: high in the cycle after each counter wrap
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n)
      vld_q <= 1'b0;
    else
      vld_q <= wrap_c;
  end

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic                pdm_in_c;
    logic                pdm_q;
    logic [WIN-1:0]      hist;
    logic [SUM_W-1:0]    sum;
    logic signed [17:0]  x_c;
    logic [15:0]         nxt_c;
    logic [15:0]         out_q;

    assign pdm_in_c = (ch == 0) ? bus.lft_PDM : bus.rght_PDM;

    // Input capture, window history and running ones-count
    always_ff @(posedge clk or negedge RST_n) begin
      if (!RST_n) begin
        pdm_q <= 1'b0;
        hist  <= HIST_RST;
        sum   <= SUM_RST;
      end else begin
        pdm_q <= pdm_in_c;
        hist  <= {hist[WIN-2:0], pdm_q};
        sum   <= sum + SUM_W'(pdm_q) - SUM_W'(hist[WIN-1]);
      end
    end

    // Centre the sum on zero and scale it to 16-bit full range
    always_comb begin
      x_c = ($signed(18'(sum)) - $signed(18'(WIN/2))) <<< SHIFT;
    end

`ifdef PDM_DEC_IIR_EN
    logic signed [17:0] y_q;
    logic signed [17:0] y_nxt_c;

    // Exponential smoothing step toward the boxcar value
    always_comb begin
      y_nxt_c = y_q + ((x_c - y_q) >>> IIR_SHIFT);
    end

    // IIR state advances only on output-update edges
    always_ff @(posedge clk or negedge RST_n) begin
      if (!RST_n)
        y_q <= '0;
      else if (wrap_c)
        y_q <= y_nxt_c;
    end

    assign nxt_c = sat16(y_nxt_c);
`else
    assign nxt_c = sat16(x_c);
`endif

    // Output sample register, loaded on update edges and held otherwise
    always_ff @(posedge clk or negedge RST_n) begin
      if (!RST_n)
        out_q <= '0;
      else if (wrap_c)
        out_q <= nxt_c;
    end
  end

  assign bus.lft_inverse  = g_ch[0].out_q;
  assign bus.rght_inverse = g_ch[1].out_q;
  assign bus.smp_vld      = vld_q;

endmodule

// File: tb/tb_pdm_decoder.sv
// Self-checking bench for pdm_decoder: two instances (DEC_LOG2 = 0 and 2) share one stimulus
// stream and are compared every cycle against a popcount-based window model.
module tb_pdm_decoder;

  localparam int WIN    = 256;
  localparam int IIR_SH = 4;

  logic clk = 1'b0;
  logic RST_n = 1'b0;

  always #5 clk = ~clk;

  pdm_decoder_if bus0 ();
  pdm_decoder_if bus2 ();

  pdm_decoder #(.WIN_LOG2(8), .DEC_LOG2(0), .IIR_SHIFT(IIR_SH)) dut0 (
    .clk(clk), .RST_n(RST_n), .bus(bus0)
  );

  pdm_decoder #(.WIN_LOG2(8), .DEC_LOG2(2), .IIR_SHIFT(IIR_SH)) dut2 (
    .clk(clk), .RST_n(RST_n), .bus(bus2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: stream of window bits per channel (front = oldest), plus per-instance state
  bit wq0[$];
  bit wq1[$];
  int pq[2];
  int cnt[2];
  int ev[2];
  int eo[2][2];
  int ey[2][2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat16(input int v);
    int r;
    r = v;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return r & 32'hFFFF;
  endfunction

  function automatic int ones_of(input int c);
    int n;
    n = 0;
    if (c == 0) begin
      foreach (wq0[k]) n += int'(wq0[k]);
    end else begin
      foreach (wq1[k]) n += int'(wq1[k]);
    end
    return n;
  endfunction

  task automatic model_reset();
    wq0.delete();
    wq1.delete();
    for (int k = 0; k < WIN; k++) begin
      wq0.push_back(bit'(k % 2));
      wq1.push_back(bit'(k % 2));
    end
    for (int i = 0; i < 2; i++) begin
      pq[i]  = 0;
      cnt[i] = 0;
      ev[i]  = 0;
      for (int c = 0; c < 2; c++) begin
        eo[i][c] = 0;
        ey[i][c] = 0;
      end
    end
  endtask

  // One rising edge of the reference: l/r are the inputs present at that edge
  task automatic model_edge(input bit l, input bit r);
    int ones[2];
    int m;
    int x;
    bit wrap;
    ones[0] = ones_of(0);
    ones[1] = ones_of(1);
    for (int i = 0; i < 2; i++) begin
      m = (i == 0) ? 1 : 4;
      wrap = (cnt[i] == m - 1);
      if (wrap) begin
        for (int c = 0; c < 2; c++) begin
          x = (ones[c] - WIN / 2) * (65536 / WIN);
`ifdef PDM_DEC_IIR_EN
          ey[i][c] = ey[i][c] + ((x - ey[i][c]) >>> IIR_SH);
          eo[i][c] = sat16(ey[i][c]);
`else
          eo[i][c] = sat16(x);
`endif
        end
      end
      ev[i]  = int'(wrap);
      cnt[i] = (cnt[i] + 1) % m;
    end
    void'(wq0.pop_front());
    wq0.push_back(bit'(pq[0]));
    void'(wq1.pop_front());
    wq1.push_back(bit'(pq[1]));
    pq[0] = int'(l);
    pq[1] = int'(r);
  endtask

  task automatic check_all();
    chk("d0_lft",  32'(bus0.lft_inverse),  32'(eo[0][0]));
    chk("d0_rght", 32'(bus0.rght_inverse), 32'(eo[0][1]));
    chk("d0_vld",  32'(bus0.smp_vld),      32'(ev[0]));
    chk("d2_lft",  32'(bus2.lft_inverse),  32'(eo[1][0]));
    chk("d2_rght", 32'(bus2.rght_inverse), 32'(eo[1][1]));
    chk("d2_vld",  32'(bus2.smp_vld),      32'(ev[1]));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_d0_lft"},  32'(bus0.lft_inverse),  32'h0);
    chk({tag, "_d0_rght"}, 32'(bus0.rght_inverse), 32'h0);
    chk({tag, "_d0_vld"},  32'(bus0.smp_vld),      32'h0);
    chk({tag, "_d2_lft"},  32'(bus2.lft_inverse),  32'h0);
    chk({tag, "_d2_rght"}, 32'(bus2.rght_inverse), 32'h0);
    chk({tag, "_d2_vld"},  32'(bus2.smp_vld),      32'h0);
  endtask

  task automatic drive(input bit l, input bit r);
    bus0.lft_PDM  = l;
    bus0.rght_PDM = r;
    bus2.lft_PDM  = l;
    bus2.rght_PDM = r;
  endtask

  // Called at a falling edge; returns at the next falling edge
  task automatic step(input bit l, input bit r);
    drive(l, r);
    @(posedge clk);
    model_edge(l, r);
    #1;
    check_all();
    @(negedge clk);
  endtask

  // Called at a falling edge; holds reset with random inputs, releases at a falling edge
  task automatic apply_reset(input int n, input bit do_chk);
    RST_n = 1'b0;
    for (int k = 0; k < n; k++) begin
      drive(bit'($urandom_range(1)), bit'($urandom_range(1)));
      @(negedge clk);
      if (do_chk) check_zero("reset");
    end
    RST_n = 1'b1;
    model_reset();
  endtask

  initial begin
    drive(1'b0, 1'b0);
    model_reset();
    @(negedge clk);

    apply_reset(5, 1'b1);

    // Alternating pattern in phase with the reset window: output must stay at zero
    for (int k = 0; k < 1000; k++) step(bit'((k + 1) % 2), bit'((k + 1) % 2));
    chk("alt_lft_end",  32'(bus0.lft_inverse),  32'h0);
    chk("alt_rght_end", 32'(bus0.rght_inverse), 32'h0);

    // Full-scale ramps in opposite directions
    apply_reset(3, 1'b0);
    for (int k = 0; k < 300; k++) step(1'b1, 1'b0);
`ifndef PDM_DEC_IIR_EN
    chk("ramp_d0_lft_end",  32'(bus0.lft_inverse),  32'h7FFF);
    chk("ramp_d0_rght_end", 32'(bus0.rght_inverse), 32'h8000);
    chk("ramp_d2_lft_end",  32'(bus2.lft_inverse),  32'h7FFF);
    chk("ramp_d2_rght_end", 32'(bus2.rght_inverse), 32'h8000);
`endif

    // 75% / 25% duty patterns
    apply_reset(3, 1'b0);
    for (int k = 0; k < 600; k++) step(bit'((k % 4) != 2), bit'((k % 4) == 2));
`ifndef PDM_DEC_IIR_EN
    chk("duty75_lft", 32'(bus0.lft_inverse),  32'h4000);
    chk("duty25_rght", 32'(bus0.rght_inverse), 32'hC000);
`endif

    // Random streams
    apply_reset(3, 1'b0);
    for (int k = 0; k < 500; k++) step(bit'($urandom_range(1)), bit'($urandom_range(1)));

    // Asynchronous reset in the middle of a ramp
    apply_reset(3, 1'b0);
    for (int k = 0; k < 100; k++) step(1'b1, 1'b0);
    #2;
    RST_n = 1'b0;
    #1;
    check_zero("async_rst");
    @(negedge clk);
    @(negedge clk);
    RST_n = 1'b1;
    model_reset();
    for (int k = 0; k < 300; k++) step(1'b1, 1'b0);
`ifndef PDM_DEC_IIR_EN
    chk("post_rst_lft_end", 32'(bus0.lft_inverse), 32'h7FFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pdm_decoder.md
Name: pdm_decoder

Overview:
- Recovers 16-bit signed PCM from the two 1-bit PDM streams (left, right) that the equalizer's PDM output stage produces.
- Each channel has its own boxcar (moving-sum) filter over the last 2^WIN_LOG2 PDM bits. The sum is scaled to 16-bit two's complement and updated at a decimated rate.
- Used as a bench-side and monitor block so downstream analyzers (zero-crossing frequency and amplitude detection) can process audio on the speaker path.

Parameters:
- WIN_LOG2, 8, log2 of the boxcar window length in PDM bits. Legal range 4..16.
- DEC_LOG2, 0, log2 of the decimation factor. Outputs update every 2^DEC_LOG2 clocks. Legal range 0..8.
- IIR_SHIFT, 4, post-filter coefficient shift. Used only when PDM_DEC_IIR_EN is defined. Legal range 1..8.

Ports:
- clk  input  1  system clock; PDM bits are valid on every rising edge.
- RST_n  input  1  reset, asynchronous, active-low.
- lft_PDM  input  1  left-channel PDM bit stream, synchronous to clk.
- rght_PDM  input  1  right-channel PDM bit stream, synchronous to clk.
- lft_inverse  output  16  left decoded sample, signed two's complement, registered.
- rght_inverse  output  16  right decoded sample, signed two's complement, registered.
- smp_vld  output  1  one-clock pulse on each clock where the outputs take a new value, registered.

Behaviour:
- Reset is asynchronous and active-low on clk; it affects every register.
- Reset values:
  - lft_inverse = rght_inverse = 0x0000; smp_vld = 0.
  - Input registers = 0; decimation counter = 0; IIR state = 0.
  - Each channel's history shift register (2^WIN_LOG2 bits) is loaded with the alternating pattern 1010…; its running sum is 2^(WIN_LOG2-1), which decodes to 0.
- Per-channel pipeline; both channels are identical, fully independent and updated in the same cycles:
  - Edge k: PDM input captured into pdm_q.
  - Edge k+1: history shifts in pdm_q and drops its oldest bit. sum <= sum + pdm_q - oldest. Sum is WIN_LOG2+1 bits wide and must never wrap.
  - Edge k+2: output register loads the scaled value, if this is a vld cycle.
- Scaling:
  - x = (sum - 2^(WIN_LOG2-1)) << (16-WIN_LOG2), computed in 18-bit signed.
  - Saturate to 0x7FFF when x > 32767; all-ones window → 0x7FFF.
  - All-zeros window → 0x8000 exactly, with no clipping.
- Decimation:
  - A free-running DEC_LOG2-bit counter starts at 0 after reset.
  - smp_vld is 1 in the cycle after the counter wraps to 0. The outputs load on that same edge and hold otherwise.
  - DEC_LOG2 = 0: smp_vld goes high on the first edge after reset release and stays high; outputs update every clock.
- Latency: a PDM bit present at edge k first affects the outputs at edge k+2 when DEC_LOG2 = 0.
- Boundary conditions:
  - Sum is bounded to 0..2^WIN_LOG2, so there is no wrap.
  - If the input bit equals the dropped bit, the sum is unchanged.
  - Reset asserted mid-stream clears everything immediately, without waiting for a clock edge. The first valid output after release follows the normal latency.
- No handshake or back-pressure; the outputs are sampled opportunistically.

Optional Feature:
- Macro name: PDM_DEC_IIR_EN.
- Defined:
  - Per channel, an 18-bit signed state y; reset 0.
  - On each vld cycle: y <= y + ((x - y) >>> IIR_SHIFT).
  - Output = y saturated to 16 bits. Latency is unchanged; the step response becomes exponential.
- Undefined: output = x directly, with no IIR logic and no extra registers.

Test Plan:
- Reset: hold RST_n = 0 for 5 clocks with random PDM inputs → both outputs 0x0000, smp_vld = 0. Release with DEC_LOG2 = 0 → smp_vld = 1 from the next edge.
- Constant lft_PDM = 1, rght_PDM = 0 for 300 clocks (defaults):
  - lft rises monotonically in steps of 0x100 and is 0x7FFF after 258 clocks.
  - rght falls monotonically and is 0x8000 after 258 clocks.
  - Confirms channel independence.
- Alternating 1010… in phase with the reset pattern, both channels → outputs stay exactly 0x0000 for 1000 clocks.
- Repeating 1101 (75% duty) for 600 clocks → steady 0x4000. Repeating 0010 (25% duty) → steady 0xC000.
- DEC_LOG2 = 2 with constant 1s:
  - smp_vld pulses every 4th clock.
  - Outputs change only on pulse cycles; the final value is 0x7FFF.
- Reset asserted mid-ramp while lft ≈ 0x3000 → lft_inverse = 0x0000 asynchronously. After release the output follows the normal ramp from 0.
